// File: rtl/fetch_unit.sv
// fetch_unit: program counter / fetch stage with IDLE/LOAD/RUN/HALTED sequencing.
// It produces the instruction-ROM address each cycle and flags run/halt status.
// Optional feature: define FETCH_CYCLE_COUNT_EN to build a saturating counter of
// cycles spent in RUN. Without it, CycleCount is tied to zero.
module fetch_unit #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             Jump,
  input  logic             BranchEn,
  input  logic             Zero,
  input  logic [PC_W-1:0]  Target,
  input  logic [OFF_W-1:0] Offset,
  input  logic             Halt,
  input  logic             Stall,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCount
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    HALTED
  } state_t;

  localparam int EXT_W = PC_W - OFF_W;

  state_t          state_q;
  state_t          state_d;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] offset_ext;
  logic [PC_W-1:0] pc_one;

  assign offset_ext = {{EXT_W{Offset[OFF_W-1]}}, Offset};
  assign pc_one     = {{(PC_W-1){1'b0}}, 1'b1};

  // State, PC and status flags; Running/Done are registered from the next state
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      ProgCtr <= '0;
      Running <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state_q <= state_d;
      ProgCtr <= pc_d;
      Running <= (state_d == RUN);
      Done    <= (state_d == HALTED);
    end
  end

  // Next-state and next-PC selection; in RUN, restart > halt > stall > jump > branch > increment
  always_comb begin
    state_d = state_q;
    pc_d    = ProgCtr;
    unique case (state_q)
      IDLE: begin
        if (Start) state_d = LOAD;
      end
      LOAD: begin
        pc_d = StartAddr;
        if (!Start) state_d = RUN;
      end
      RUN: begin
        if (Start) begin
          state_d = LOAD;
        end else if (Halt) begin
          state_d = HALTED;
        end else if (Stall) begin
          pc_d = ProgCtr;
        end else if (Jump) begin
          pc_d = Target;
        end else if (BranchEn && Zero) begin
          pc_d = ProgCtr + offset_ext;
        end else begin
          pc_d = ProgCtr + pc_one;
        end
      end
      HALTED: begin
        if (Start) state_d = LOAD;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef FETCH_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating RUN-cycle counter: cleared in LOAD, held in IDLE and HALTED
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else if (state_q == LOAD) begin
      cnt_q <= '0;
    end else if ((state_q == RUN) && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign CycleCount = cnt_q;
`else
  assign CycleCount = '0;
`endif

endmodule
